seq_detector_param: RTL and testbench

// Parametrised serial bit-pattern detector, successor of the fixed Moore "0110" detector.

---
 rtl/sd_pkg.sv | 16 +
 rtl/sat_counter.sv | 28 ++
 rtl/seq_detector_param.sv | 144 ++++++++++++++
 tb/tb_seq_detector_param.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// Shared definitions for the parametrised serial pattern detector.
//   state_t / ST_*  : detector state encoding
//   len_w()         : width needed to hold a pattern length of 0..max_len
package sd_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;  // no valid pattern loaded
  localparam state_t ST_FILL = 2'd1;  // collecting bits, fill < len
  localparam state_t ST_HUNT = 2'd2;  // fill >= len, comparing every bit

  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk   : clock, posedge
//   rst_n : synchronous reset, active-low
//   inc   : count one event this cycle
//   clr   : clear; when asserted together with inc the result is 1
//   q     : count, holds at all-ones instead of wrapping
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      // The event that arrives in the clear cycle is still counted.
      q <= inc ? CNT_W'(1) : '0;
    end else if (inc && (q != '1)) begin
      q <= q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Serial bit-pattern detector with a run-time loadable pattern of 1..MAX_LEN bits.
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | no valid pattern; X ignored, Z stays 0
// FILL    | pattern loaded, fewer than len bits collected
// HUNT    | at least len bits collected, comparing each bit
//
// Ports
//   CLOCK     : clock, all logic on posedge
//   RESET_N   : synchronous reset, active-low, overrides everything
//   LOAD      : latch PAT_IN/LEN_IN (LEN_IN outside 1..MAX_LEN disarms)
//   PAT_IN    : pattern, bit LEN-1 is the first bit received
//   LEN_IN    : pattern length
//   EN        : X is valid this cycle
//   X         : serial data bit
//   OVERLAP   : 1 = a match may reuse bits of the previous match
//   CLR_CNT   : clear MATCH_CNT
//   Z         : one-cycle pulse the cycle after the final matching bit
//   MATCH_CNT : saturating count of matches
//   ARMED     : a valid pattern is loaded
module seq_detector_param
  import sd_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  localparam int LEN_W  = len_w(MAX_LEN)
) (
  input  logic               CLOCK,
  input  logic               RESET_N,
  input  logic               LOAD,
  input  logic [MAX_LEN-1:0] PAT_IN,
  input  logic [LEN_W-1:0]   LEN_IN,
  input  logic               EN,
  input  logic               X,
  input  logic               OVERLAP,
  input  logic               CLR_CNT,
  output logic               Z,
  output logic [CNT_W-1:0]   MATCH_CNT,
  output logic               ARMED
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  state_t             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic [MAX_LEN-1:0] hist_q;
  logic [LEN_W-1:0]   fill_q;
  logic               z_q;

  logic               load_ok;
  logic               shift_en;
  logic [MAX_LEN-1:0] hist_shift;
  logic [LEN_W-1:0]   fill_inc;
  logic [MAX_LEN-1:0] len_mask;
  logic               hit;

  assign load_ok    = LOAD && (LEN_IN != '0) && (LEN_IN <= LEN_MAX);
  assign shift_en   = EN && !LOAD && (state_q != ST_IDLE);
  assign hist_shift = {hist_q[MAX_LEN-2:0], X};
  assign fill_inc   = (fill_q >= LEN_MAX) ? LEN_MAX : fill_q + LEN_W'(1);

  // Only the low len bits of history and pattern take part in the compare.
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (int'(len_q) > i);
    end
  end

  // State register
  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (LOAD) begin
      state_d = load_ok ? ST_FILL : ST_IDLE;
    end else if (shift_en) begin
      if (hit && !OVERLAP) begin
        state_d = ST_FILL;
      end else if (fill_inc >= len_q) begin
        state_d = ST_HUNT;
      end else begin
        state_d = ST_FILL;
      end
    end
  end

  // Output / match decode, evaluated on the post-shift history and fill.
  always_comb begin
    hit = 1'b0;
    if (shift_en && (fill_inc >= len_q)) begin
      hit = (((hist_shift ^ pat_q) & len_mask) == '0);
    end
  end

  assign Z     = z_q;
  assign ARMED = (state_q != ST_IDLE);

  // Pattern, history, fill and match pulse
  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      pat_q  <= '0;
      len_q  <= '0;
      hist_q <= '0;
      fill_q <= '0;
      z_q    <= 1'b0;
    end else begin
      z_q <= hit;
      if (LOAD) begin
        // Any load restarts collection; the X of this cycle is dropped.
        hist_q <= '0;
        fill_q <= '0;
        if (load_ok) begin
          pat_q <= PAT_IN;
          len_q <= LEN_IN;
        end
      end else if (shift_en) begin
        hist_q <= hist_shift;
        // Non-overlap: the next match must be built from len fresh bits.
        fill_q <= (hit && !OVERLAP) ? '0 : fill_inc;
      end
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk  (CLOCK),
    .rst_n(RESET_N),
    .inc  (hit),
    .clr  (CLR_CNT),
    .q    (MATCH_CNT)
  );

endmodule

// File: tb/tb_seq_detector_param.sv
module tb_seq_detector_param;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic               CLOCK = 1'b0;
  logic               RESET_N;
  logic               LOAD;
  logic [MAX_LEN-1:0] PAT_IN;
  logic [LEN_W-1:0]   LEN_IN;
  logic               EN;
  logic               X;
  logic               OVERLAP;
  logic               CLR_CNT;
  logic               Z, Z2;
  logic [7:0]         MATCH_CNT;
  logic [1:0]         MATCH_CNT2;
  logic               ARMED, ARMED2;

  int vectors = 0;
  int miscompares = 0;
  bit checking = 0;

  always #5 CLOCK = ~CLOCK;

  seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(8)) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .LOAD(LOAD), .PAT_IN(PAT_IN), .LEN_IN(LEN_IN),
    .EN(EN), .X(X), .OVERLAP(OVERLAP), .CLR_CNT(CLR_CNT),
    .Z(Z), .MATCH_CNT(MATCH_CNT), .ARMED(ARMED)
  );

  seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut2 (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .LOAD(LOAD), .PAT_IN(PAT_IN), .LEN_IN(LEN_IN),
    .EN(EN), .X(X), .OVERLAP(OVERLAP), .CLR_CNT(CLR_CNT),
    .Z(Z2), .MATCH_CNT(MATCH_CNT2), .ARMED(ARMED2)
  );

  // Reference model: keeps the received bits as a list and counts how many
  // have arrived since the last load or non-overlapping match.
  bit  m_armed = 0;
  bit  m_pat [MAX_LEN];
  int  m_len = 0;
  bit  m_bits[$];
  int  m_fresh = 0;
  bit  m_z = 0;
  int  m_cnt = 0;
  int  m_cnt2 = 0;

  always @(posedge CLOCK) begin
    bit match;
    match = 0;
    if (!RESET_N) begin
      m_armed = 0; m_len = 0; m_bits.delete(); m_fresh = 0; m_cnt = 0; m_cnt2 = 0;
      foreach (m_pat[i]) m_pat[i] = 0;
    end else begin
      if (LOAD) begin
        m_bits.delete();
        m_fresh = 0;
        if (LEN_IN >= 1 && LEN_IN <= MAX_LEN) begin
          m_armed = 1;
          m_len = LEN_IN;
          foreach (m_pat[i]) m_pat[i] = PAT_IN[i];
        end else begin
          m_armed = 0;
        end
      end else if (EN && m_armed) begin
        m_bits.push_back(X);
        if (m_bits.size() > MAX_LEN) void'(m_bits.pop_front());
        m_fresh++;
        if (m_fresh >= m_len) begin
          match = 1;
          for (int i = 0; i < m_len; i++)
            if (m_bits[m_bits.size() - 1 - i] != m_pat[i]) match = 0;
          if (match && !OVERLAP) m_fresh = 0;
        end
      end
      if (CLR_CNT) begin
        m_cnt  = match ? 1 : 0;
        m_cnt2 = match ? 1 : 0;
      end else if (match) begin
        m_cnt  = (m_cnt  < 255) ? m_cnt  + 1 : 255;
        m_cnt2 = (m_cnt2 < 3)   ? m_cnt2 + 1 : 3;
      end
    end
    m_z = RESET_N ? match : 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLOCK) begin
    if (checking) begin
      check("z",      {31'd0, Z},      {31'd0, m_z});
      check("z2",     {31'd0, Z2},     {31'd0, m_z});
      check("armed",  {31'd0, ARMED},  {31'd0, m_armed});
      check("cnt",    {24'd0, MATCH_CNT},  32'(m_cnt));
      check("cnt2",   {30'd0, MATCH_CNT2}, 32'(m_cnt2));
    end
  end

  task automatic drive(input logic ld, input logic [7:0] pat, input logic [3:0] len,
                       input logic en, input logic x, input logic clr);
    LOAD = ld; PAT_IN = pat; LEN_IN = len; EN = en; X = x; CLR_CNT = clr;
    @(posedge CLOCK); #1;
  endtask

  task automatic bitin(input logic x);
    drive(1'b0, PAT_IN, LEN_IN, 1'b1, x, 1'b0);
  endtask

  task automatic gap(input logic x);
    drive(1'b0, PAT_IN, LEN_IN, 1'b0, x, 1'b0);
  endtask

  task automatic load(input logic [7:0] pat, input logic [3:0] len);
    drive(1'b1, pat, len, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    drive(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
    RESET_N = 1'b1;
  endtask

  initial begin
    RESET_N = 1'b0; LOAD = 0; PAT_IN = 0; LEN_IN = 0; EN = 0; X = 0; OVERLAP = 1; CLR_CNT = 0;
    @(posedge CLOCK); #1;
    checking = 1;
    check("rst_z", {31'd0, Z}, 32'd0);
    check("rst_cnt", {24'd0, MATCH_CNT}, 32'd0);
    check("rst_armed", {31'd0, ARMED}, 32'd0);
    RESET_N = 1'b1;

    // 1: overlapping 0110 in 0110110
    OVERLAP = 1;
    load(8'b0110, 4'd4);
    check("t1_armed", {31'd0, ARMED}, 32'd1);
    bitin(0); bitin(1); bitin(1);
    check("t1_z3", {31'd0, Z}, 32'd0);
    bitin(0);
    check("t1_z4", {31'd0, Z}, 32'd1);
    bitin(1);
    check("t1_z5", {31'd0, Z}, 32'd0);
    bitin(1); bitin(0);
    check("t1_z7", {31'd0, Z}, 32'd1);
    check("t1_cnt", {24'd0, MATCH_CNT}, 32'd2);

    // 2: same stream, non-overlapping
    do_reset();
    OVERLAP = 0;
    load(8'b0110, 4'd4);
    bitin(0); bitin(1); bitin(1); bitin(0);
    check("t2_z4", {31'd0, Z}, 32'd1);
    bitin(1); bitin(1); bitin(0);
    check("t2_z7", {31'd0, Z}, 32'd0);
    check("t2_cnt", {24'd0, MATCH_CNT}, 32'd1);

    // 3: EN gaps, tempting X values while EN=0
    do_reset();
    OVERLAP = 1;
    load(8'b0110, 4'd4);
    bitin(0); gap(1); gap(1); gap(0);
    check("t3_gap", {31'd0, Z}, 32'd0);
    bitin(1); bitin(1); bitin(0);
    check("t3_z", {31'd0, Z}, 32'd1);
    gap(0);
    check("t3_after", {31'd0, Z}, 32'd0);

    // 4: reload mid-stream, X of the load cycle dropped
    do_reset();
    load(8'b0110, 4'd4);
    bitin(0); bitin(1); bitin(1);
    drive(1'b1, 8'b101, 4'd3, 1'b1, 1'b0, 1'b0);
    check("t4_load", {31'd0, Z}, 32'd0);
    bitin(1); bitin(0);
    check("t4_z2", {31'd0, Z}, 32'd0);
    bitin(1);
    check("t4_z", {31'd0, Z}, 32'd1);
    bitin(0); bitin(1);
    check("t4_ovl", {31'd0, Z}, 32'd1);

    // 5: len=1, saturation of the 2-bit counter, clear with match
    do_reset();
    OVERLAP = 0;
    load(8'b1, 4'd1);
    bitin(1); check("t5_c1", {30'd0, MATCH_CNT2}, 32'd1);
    bitin(1); check("t5_c2", {30'd0, MATCH_CNT2}, 32'd2);
    bitin(1); check("t5_c3", {30'd0, MATCH_CNT2}, 32'd3);
    bitin(1); check("t5_c4", {30'd0, MATCH_CNT2}, 32'd3);
    bitin(1); check("t5_c5", {30'd0, MATCH_CNT2}, 32'd3);
    check("t5_c8", {24'd0, MATCH_CNT}, 32'd5);
    drive(1'b0, PAT_IN, LEN_IN, 1'b1, 1'b1, 1'b1);
    check("t5_clrhit", {30'd0, MATCH_CNT2}, 32'd1);
    bitin(0);
    check("t5_miss", {31'd0, Z}, 32'd0);
    drive(1'b0, PAT_IN, LEN_IN, 1'b0, 1'b1, 1'b1);
    check("t5_clr", {30'd0, MATCH_CNT2}, 32'd0);
    load(8'b0110, 4'd4);
    check("t5_keep", {24'd0, MATCH_CNT}, 32'd0);
    bitin(1); bitin(1); bitin(0);
    check("t5_cnt_load", {24'd0, MATCH_CNT}, 32'd0);

    // 6: reset mid-stream overrides a load, then invalid lengths disarm
    do_reset();
    OVERLAP = 1;
    load(8'b0110, 4'd4);
    bitin(0); bitin(1); bitin(1);
    RESET_N = 1'b0;
    drive(1'b1, 8'b1, 4'd1, 1'b1, 1'b0, 1'b0);
    RESET_N = 1'b1;
    check("t6_z", {31'd0, Z}, 32'd0);
    check("t6_armed", {31'd0, ARMED}, 32'd0);
    check("t6_cnt", {24'd0, MATCH_CNT}, 32'd0);
    bitin(0);
    check("t6_idle", {31'd0, Z}, 32'd0);
    load(8'b0110, 4'd0);
    check("t6_len0", {31'd0, ARMED}, 32'd0);
    bitin(0); bitin(1); bitin(1); bitin(0);
    check("t6_nomatch", {31'd0, Z}, 32'd0);
    load(8'b0110, 4'd4);
    load(8'b0110, 4'd9);
    check("t6_len9", {31'd0, ARMED}, 32'd0);
    load(8'hA5, 4'd8);
    bitin(1); bitin(0); bitin(1); bitin(0); bitin(0); bitin(1); bitin(0); bitin(1);
    check("t6_len8", {31'd0, Z}, 32'd1);
    gap(0);

    checking = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
